chromosome_serial_loader: RTL and testbench
===========================================

// Module: chromosome_serial_loader
// PURPOSE
//  Serial front end of the genetic circuit: receives a chromosome one bit at a time from the
//  host/GA link and presents it as a parallel word to the genetic-circuit top (LUT truth tables + output selectors).
//  The shadow register is copied to the output only after a full frame passes its parity check.
//  The evaluated circuit therefore never sees a partial or corrupt chromosome.
// PARAMETERS
//  BITS_MAT     32     total truth-table bits (ROW*COL*16)
//  BITS_ELEM    2      selector bits per circuit output
//  OUT          1      number of circuit outputs
//  TIMEOUT_CYC  1024   max idle cycles between bits inside a frame before abort (>=2)
//  CHROM_RESET  0      chromosome value after reset; CHROM_BITS wide
//  localparam CHROM_BITS = BITS_MAT + BITS_ELEM*OUT (34 at defaults)
// PORTS
//  clk          in   1           system clock; all logic on rising edge
//  rst          in   1           synchronous reset, active-high
//  ser_start    in   1           1-cycle pulse: begin a new frame
//  ser_valid    in   1           ser_data is valid this cycle
//  ser_data     in   1           serial bit
//  cromossomo   out  CHROM_BITS  committed chromosome, to the genetic top
//  chrom_valid  out  1           high once any frame has been committed
//  load_done    out  1           1-cycle pulse: new chromosome committed
//  load_err     out  1           1-cycle pulse: frame rejected (parity/abort/timeout)
//  busy         out  1           state != IDLE
//  frame_cnt    out  8           count of committed frames; wraps 255->0
// BEHAVIOUR
//  Reset values:
//   - cromossomo=CHROM_RESET; chrom_valid=0; load_done=0; load_err=0.
//   - busy=0; frame_cnt=0; state=IDLE; bit counter=0; timeout counter=0.
//  Frame format:
//   - CHROM_BITS data bits, LSB first: the k-th accepted bit (k from 0) goes to shadow[k].
//   - Then 1 parity bit. Even parity: XOR of all data bits and the parity bit must be 0.
//  FSM:
//   - IDLE: ser_valid ignored. ser_start -> SHIFT, bit cnt=0, timeout cnt=0.
//   - SHIFT: ser_valid -> shadow[cnt]=ser_data, cnt++, timeout cnt=0.
//     After bit CHROM_BITS-1 is accepted -> PARITY.
//   - PARITY: ser_valid with parity OK -> cromossomo<=shadow, chrom_valid<=1, load_done=1,
//     frame_cnt++, -> IDLE. Parity bad -> load_err=1, cromossomo unchanged, -> IDLE.
//  Latency:
//   - Parity bit sampled at edge N; cromossomo and load_done are updated at that same edge,
//     so both are visible in the following cycle.
//   - load_done and load_err are high for exactly 1 cycle.
//  Timeout (SHIFT/PARITY only):
//   - Counter increments each cycle with ser_valid=0.
//   - At TIMEOUT_CYC: load_err=1, -> IDLE, shadow discarded.
//  ser_start while in SHIFT/PARITY:
//   - Current frame aborted, load_err=1, restart in SHIFT with cnt=0.
//   - ser_start and ser_valid in the same cycle: start wins; that data bit is NOT captured.
//  The shadow register is never visible on cromossomo; cromossomo changes only on commit or rst.
//  rst mid-frame: everything returns to reset values, including cromossomo=CHROM_RESET.
//  No error pulse is issued on rst.
//  busy is registered: it rises the cycle after ser_start and falls with load_done/load_err.
// TESTING
//  1. Send 34'h2_0100_1000 LSB first, parity=1 -> cromossomo=34'h2_0100_1000, load_done 1 cycle, frame_cnt=1, chrom_valid=1.
//  2. Same frame with parity=0 -> load_err pulse, cromossomo keeps prior value, frame_cnt unchanged.
//  3. Gaps: ser_valid low 3 cycles between random bits -> correct commit.
//     Gap of TIMEOUT_CYC after bit 10 -> load_err, busy=0.
//  4. ser_start after 20 bits, then a full good frame 34'h0_0000_FFFF -> 1 load_err, then commit 34'h0_0000_FFFF.
//  5. rst asserted at bit 17 -> cromossomo=CHROM_RESET, outputs at reset values; next good frame commits normally.
//  6. 256 good frames -> frame_cnt wraps to 0; ser_valid in IDLE with no start -> no state change.

Source files
------------

// File: rtl/chromosome_serial_loader.sv
// Serial chromosome loader: shifts a parity-protected frame in LSB first and
// commits it to the parallel chromosome output only after the parity bit checks out.
module chromosome_serial_loader #(
  parameter int BITS_MAT    = 32,
  parameter int BITS_ELEM   = 2,
  parameter int OUT         = 1,
  parameter int TIMEOUT_CYC = 1024,
  parameter logic [BITS_MAT+BITS_ELEM*OUT-1:0] CHROM_RESET = '0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                ser_start,
  input  logic                                ser_valid,
  input  logic                                ser_data,
  output logic [BITS_MAT+BITS_ELEM*OUT-1:0]   cromossomo,
  output logic                                chrom_valid,
  output logic                                load_done,
  output logic                                load_err,
  output logic                                busy,
  output logic [7:0]                          frame_cnt
);

  localparam int CHROM_BITS = BITS_MAT + BITS_ELEM * OUT;
  localparam int CW = $clog2(CHROM_BITS + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [TW-1:0]           tmo_q, tmo_d;
  logic [CHROM_BITS-1:0]   shadow_q, shadow_d;
  logic                    par_q, par_d;
  logic [CHROM_BITS-1:0]   chrom_q;
  logic                    chrom_valid_q;
  logic                    load_done_q;
  logic                    load_err_q;
  logic                    busy_q;
  logic [7:0]              frame_cnt_q;
  logic                    commit_s;
  logic                    err_s;

  // Even parity holds when the running XOR of the data bits cancels the parity bit.
  function automatic logic parity_ok(input logic acc, input logic pbit);
    return (acc ^ pbit) == 1'b0;
  endfunction

  // Next-state logic: start has priority over data, data over timeout.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    shadow_d = shadow_q;
    par_d    = par_q;
    commit_s = 1'b0;
    err_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (ser_start) begin
          state_d  = SHIFT;
          cnt_d    = '0;
          tmo_d    = '0;
          par_d    = 1'b0;
          shadow_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT, PARITY: begin
        if (ser_start) begin
          err_s    = 1'b1;
          state_d  = SHIFT;
          cnt_d    = '0;
          tmo_d    = '0;
          par_d    = 1'b0;
          shadow_d = '0;
        end else if (ser_valid) begin
          tmo_d = '0;
          if (state_q == SHIFT) begin
            shadow_d[cnt_q] = ser_data;
            par_d           = par_q ^ ser_data;
            cnt_d           = cnt_q + CW'(1);
            if (cnt_q == CW'(CHROM_BITS - 1)) begin
              state_d = PARITY;
            end else begin
              state_d = SHIFT;
            end
          end else begin
            if (parity_ok(par_q, ser_data)) begin
              commit_s = 1'b1;
            end else begin
              err_s = 1'b1;
            end
            state_d = IDLE;
          end
        end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
          err_s   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, shadow and registered outputs; the shadow only reaches cromossomo on commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      tmo_q         <= '0;
      shadow_q      <= '0;
      par_q         <= 1'b0;
      chrom_q       <= CHROM_RESET;
      chrom_valid_q <= 1'b0;
      load_done_q   <= 1'b0;
      load_err_q    <= 1'b0;
      busy_q        <= 1'b0;
      frame_cnt_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      shadow_q    <= shadow_d;
      par_q       <= par_d;
      load_done_q <= commit_s;
      load_err_q  <= err_s;
      busy_q      <= (state_d != IDLE);
      if (commit_s) begin
        chrom_q       <= shadow_q;
        chrom_valid_q <= 1'b1;
        frame_cnt_q   <= frame_cnt_q + 8'd1;
      end else begin
        chrom_q       <= chrom_q;
        chrom_valid_q <= chrom_valid_q;
        frame_cnt_q   <= frame_cnt_q;
      end
    end
  end

  assign cromossomo  = chrom_q;
  assign chrom_valid = chrom_valid_q;
  assign load_done   = load_done_q;
  assign load_err    = load_err_q;
  assign busy        = busy_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_chromosome_serial_loader.sv
// Bench for chromosome_serial_loader: frame-level reference model (bit queue plus
// idle counter) compared against the DUT every cycle, plus literal spot checks.
module tb_chromosome_serial_loader;

  localparam int CB  = 34;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          ser_start, ser_valid, ser_data;
  logic [CB-1:0] cromossomo;
  logic          chrom_valid, load_done, load_err, busy;
  logic [7:0]    frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int err_pulses = 0;

  chromosome_serial_loader #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .ser_start(ser_start), .ser_valid(ser_valid),
    .ser_data(ser_data), .cromossomo(cromossomo), .chrom_valid(chrom_valid),
    .load_done(load_done), .load_err(load_err), .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit          m_on = 1'b0;
  bit          m_in;
  bit          q[$];
  int          m_idle;
  logic [CB-1:0] m_chrom;
  bit          m_cv, m_done, m_err;
  logic [7:0]  m_fcnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a frame is a queue of received bits; commit when CB bits plus an even-parity bit arrive.
  always @(posedge clk) begin
    int ones;
    m_done = 1'b0;
    m_err  = 1'b0;
    if (rst) begin
      m_on = 1'b1; m_in = 1'b0; q.delete(); m_idle = 0;
      m_chrom = '0; m_cv = 1'b0; m_fcnt = 8'd0;
    end else if (ser_start) begin
      if (m_in) m_err = 1'b1;
      m_in = 1'b1; q.delete(); m_idle = 0;
    end else if (m_in) begin
      if (ser_valid) begin
        m_idle = 0;
        if (q.size() < CB) begin
          q.push_back(ser_data);
        end else begin
          ones = int'(ser_data);
          foreach (q[i]) ones += int'(q[i]);
          if (ones % 2 == 0) begin
            for (int k = 0; k < CB; k++) m_chrom[k] = q[k];
            m_cv = 1'b1; m_done = 1'b1; m_fcnt = m_fcnt + 8'd1;
          end else begin
            m_err = 1'b1;
          end
          m_in = 1'b0;
        end
      end else begin
        m_idle++;
        if (m_idle == TMO) begin
          m_err = 1'b1; m_in = 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_on) begin
      check("cromossomo", 64'(cromossomo), 64'(m_chrom));
      check("chrom_valid", 64'(chrom_valid), 64'(m_cv));
      check("load_done", 64'(load_done), 64'(m_done));
      check("load_err", 64'(load_err), 64'(m_err));
      check("busy", 64'(busy), 64'(m_in));
      check("frame_cnt", 64'(frame_cnt), 64'(m_fcnt));
      if (load_err === 1'b1) err_pulses++;
    end
  end

  task automatic cyc(input logic s, input logic v, input logic d);
    ser_start = s; ser_valid = v; ser_data = d;
    @(posedge clk);
    #1;
  endtask

  // gap >= 0: fixed idle cycles before each bit; gap < 0: random 0..3.
  task automatic send_frame(input logic [CB-1:0] w, input bit good, input int gap,
                            input int long_at, input logic start_valid);
    int g;
    logic b;
    cyc(1'b1, start_valid, 1'b1);
    for (int k = 0; k < CB + 1; k++) begin
      if (k == long_at) g = TMO - 1;
      else if (gap >= 0) g = gap;
      else g = int'($urandom_range(3, 0));
      repeat (g) cyc(1'b0, 1'b0, 1'($urandom));
      if (k < CB) b = w[k];
      else b = (^w) ^ (good ? 1'b0 : 1'b1);
      cyc(1'b0, 1'b1, b);
    end
  endtask

  task automatic send_bits(input int n);
    cyc(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b1, 1'($urandom));
  endtask

  initial begin
    logic [CB-1:0] w;
    int e0, r;
    rst = 1'b1; ser_start = 1'b0; ser_valid = 1'b0; ser_data = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    check("rst_crom", 64'(cromossomo), 64'd0);
    check("rst_cv", 64'(chrom_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_fcnt", 64'(frame_cnt), 64'd0);

    // Known good frame
    send_frame(34'h2_0100_1000, 1'b1, 0, -1, 1'b0);
    check("t1_done", 64'(load_done), 64'd1);
    check("t1_crom", 64'(cromossomo), 64'h2_0100_1000);
    check("t1_model", 64'(m_chrom), 64'h2_0100_1000);
    check("t1_fcnt", 64'(frame_cnt), 64'd1);
    check("t1_cv", 64'(chrom_valid), 64'd1);
    cyc(1'b0, 1'b0, 1'b0);
    check("t1_done_1cyc", 64'(load_done), 64'd0);

    // Same frame, wrong parity
    send_frame(34'h2_0100_1000, 1'b0, 0, -1, 1'b0);
    check("t2_err", 64'(load_err), 64'd1);
    check("t2_crom", 64'(cromossomo), 64'h2_0100_1000);
    check("t2_fcnt", 64'(frame_cnt), 64'd1);

    // Gaps of 3, a gap just under the timeout, then a real timeout
    w = 34'({$urandom(), $urandom()});
    send_frame(w, 1'b1, 3, -1, 1'b0);
    check("t3_gap_crom", 64'(cromossomo), 64'(w));
    w = 34'({$urandom(), $urandom()});
    send_frame(w, 1'b1, 0, 5, 1'b0);
    check("t3_long_crom", 64'(cromossomo), 64'(w));
    send_bits(11);
    repeat (TMO - 1) cyc(1'b0, 1'b0, 1'b0);
    check("t3_pre_tmo_busy", 64'(busy), 64'd1);
    cyc(1'b0, 1'b0, 1'b0);
    check("t3_tmo_err", 64'(load_err), 64'd1);
    check("t3_tmo_busy", 64'(busy), 64'd0);
    check("t3_tmo_fcnt", 64'(frame_cnt), 64'd3);

    // Restart after 20 bits; restart cycle also carries a data bit that must be dropped
    send_bits(20);
    e0 = err_pulses;
    send_frame(34'h0_0000_FFFF, 1'b1, 0, -1, 1'b1);
    check("t4_crom", 64'(cromossomo), 64'h0_0000_FFFF);
    check("t4_errs", 64'(err_pulses - e0), 64'd1);

    // Reset mid-frame
    send_bits(17);
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    check("t5_crom", 64'(cromossomo), 64'd0);
    check("t5_fcnt", 64'(frame_cnt), 64'd0);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_err", 64'(load_err), 64'd0);
    w = 34'({$urandom(), $urandom()});
    send_frame(w, 1'b1, -1, -1, 1'b0);
    check("t5_recommit", 64'(cromossomo), 64'(w));

    // Random mix of good, bad, aborted and timed-out frames
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(9, 0));
      w = 34'({$urandom(), $urandom()});
      if (r < 5) send_frame(w, 1'b1, -1, -1, 1'($urandom));
      else if (r < 7) send_frame(w, 1'b0, -1, -1, 1'b0);
      else if (r < 9) send_bits(int'($urandom_range(CB, 0)));
      else begin
        send_bits(int'($urandom_range(CB, 0)));
        repeat (TMO) cyc(1'b0, 1'b0, 1'b0);
      end
      repeat ($urandom_range(2, 0)) cyc(1'b0, 1'($urandom), 1'($urandom));
    end

    // 256 commits wrap the frame counter
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 256; i++) send_frame(34'({$urandom(), $urandom()}), 1'b1, 0, -1, 1'b0);
    check("t6_wrap", 64'(frame_cnt), 64'd0);
    check("t6_model_wrap", 64'(m_fcnt), 64'd0);
    check("t6_cv", 64'(chrom_valid), 64'd1);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'($urandom));
    check("t6_idle_busy", 64'(busy), 64'd0);
    check("t6_idle_fcnt", 64'(frame_cnt), 64'd0);
    cyc(1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
